// File: rtl/time_set_sequencer_if.sv
// Front-panel bundle between the button/1 Hz sources, the time counters and
// the time-set sequencer.
interface time_set_sequencer_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_confirm;
    logic       btn_cancel;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       clock_pause;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [2:0] edit_field;

    modport master (
        output tick_1hz, btn_mode, btn_inc, btn_confirm, btn_cancel,
               cur_hour, cur_min, cur_sec,
        input  clock_pause, load, load_hour, load_min, load_sec,
               alarm_hour, alarm_min, edit_field
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, btn_confirm, btn_cancel,
               cur_hour, cur_min, cur_sec,
        output clock_pause, load, load_hour, load_min, load_sec,
               alarm_hour, alarm_min, edit_field
    );
endinterface

// File: rtl/time_set_sequencer.sv
// Edit-mode sequencer for clock time and alarm time: pauses the counters while
// clock fields are edited, issues a one-cycle load on confirm, owns the alarm.
module time_set_sequencer #(
    parameter int TIMEOUT_S          = 10,
    parameter int ALARM_HOUR_DEFAULT = 7,
    parameter int ALARM_MIN_DEFAULT  = 0
) (
    input  logic                clk_50m,
    input  logic                cr,
    time_set_sequencer_if.slave bus
);

    // Encoding doubles as the edit_field display code.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_C_HOUR = 3'd1,
        S_C_MIN  = 3'd2,
        S_C_SEC  = 3'd3,
        S_A_HOUR = 3'd4,
        S_A_MIN  = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_L  = 8'(TIMEOUT_S);
    localparam logic [4:0] ALARM_H_RST = 5'(ALARM_HOUR_DEFAULT);
    localparam logic [5:0] ALARM_M_RST = 6'(ALARM_MIN_DEFAULT);

    function automatic logic [4:0] inc_hour(input logic [4:0] v);
        if (v >= 5'd23) inc_hour = 5'd0;
        else            inc_hour = v + 5'd1;
    endfunction

    function automatic logic [5:0] inc_sixty(input logic [5:0] v);
        if (v >= 6'd59) inc_sixty = 6'd0;
        else            inc_sixty = v + 6'd1;
    endfunction

    function automatic logic is_clock_state(input state_t s);
        is_clock_state = (s == S_C_HOUR) || (s == S_C_MIN) || (s == S_C_SEC);
    endfunction

    function automatic state_t advance(input state_t s);
        case (s)
            S_C_HOUR: advance = S_C_MIN;
            S_C_MIN:  advance = S_C_SEC;
            S_C_SEC:  advance = S_A_HOUR;
            S_A_HOUR: advance = S_A_MIN;
            default:  advance = S_IDLE;
        endcase
    endfunction

    state_t     state_r;
    state_t     next_s;
    logic       timeout_hit_s;
    logic [7:0] tmo_r;
    logic [4:0] e_h_r;
    logic [5:0] e_m_r;
    logic [5:0] e_s_r;
    logic [4:0] ea_h_r;
    logic [5:0] ea_m_r;
    logic       load_r;
    logic       pause_r;
    logic [2:0] field_r;
    logic [4:0] load_hour_r;
    logic [5:0] load_min_r;
    logic [5:0] load_sec_r;
    logic [4:0] alarm_hour_r;
    logic [5:0] alarm_min_r;

    // Next-state decode with cancel > confirm > mode > inc priority.
    always_comb begin
        next_s        = state_r;
        timeout_hit_s = ((tmo_r + 8'd1) == TIMEOUT_L);
        case (state_r)
            S_IDLE: begin
                if (bus.btn_mode) next_s = S_C_HOUR;
                else              next_s = S_IDLE;
            end
            S_C_HOUR, S_C_MIN, S_C_SEC, S_A_HOUR, S_A_MIN: begin
                if (bus.btn_cancel || bus.btn_confirm)  next_s = S_IDLE;
                else if (bus.btn_mode)                  next_s = advance(state_r);
                else if (bus.btn_inc)                   next_s = state_r;
                else if (bus.tick_1hz && timeout_hit_s) next_s = S_IDLE;
                else                                    next_s = state_r;
            end
            default: next_s = S_IDLE;
        endcase
    end

    // State, edit/alarm registers, timeout counter and all registered outputs.
    always_ff @(posedge clk_50m or posedge cr) begin
        if (cr) begin
            state_r      <= S_IDLE;
            tmo_r        <= 8'd0;
            e_h_r        <= 5'd0;
            e_m_r        <= 6'd0;
            e_s_r        <= 6'd0;
            ea_h_r       <= 5'd0;
            ea_m_r       <= 6'd0;
            load_r       <= 1'b0;
            pause_r      <= 1'b0;
            field_r      <= 3'd0;
            load_hour_r  <= 5'd0;
            load_min_r   <= 6'd0;
            load_sec_r   <= 6'd0;
            alarm_hour_r <= ALARM_H_RST;
            alarm_min_r  <= ALARM_M_RST;
        end else begin
            state_r <= next_s;
            field_r <= next_s;
            pause_r <= is_clock_state(next_s);
            load_r  <= 1'b0;
            if (state_r == S_IDLE) begin
                tmo_r <= 8'd0;
                if (bus.btn_mode) begin
                    e_h_r <= bus.cur_hour;
                    e_m_r <= bus.cur_min;
                    e_s_r <= bus.cur_sec;
                end else begin
                    e_h_r <= e_h_r;
                end
            end else if (bus.btn_cancel) begin
                tmo_r <= 8'd0;
            end else if (bus.btn_confirm) begin
                tmo_r <= 8'd0;
                if (is_clock_state(state_r)) begin
                    load_r      <= 1'b1;
                    load_hour_r <= e_h_r;
                    load_min_r  <= e_m_r;
                    load_sec_r  <= e_s_r;
                end else begin
                    alarm_hour_r <= ea_h_r;
                    alarm_min_r  <= ea_m_r;
                end
            end else if (bus.btn_mode) begin
                tmo_r <= 8'd0;
                // Entering alarm editing starts from the committed alarm time.
                if (state_r == S_C_SEC) begin
                    ea_h_r <= alarm_hour_r;
                    ea_m_r <= alarm_min_r;
                end else begin
                    ea_h_r <= ea_h_r;
                end
            end else if (bus.btn_inc) begin
                tmo_r <= 8'd0;
                case (state_r)
                    S_C_HOUR: e_h_r  <= inc_hour(e_h_r);
                    S_C_MIN:  e_m_r  <= inc_sixty(e_m_r);
                    S_C_SEC:  e_s_r  <= inc_sixty(e_s_r);
                    S_A_HOUR: ea_h_r <= inc_hour(ea_h_r);
                    S_A_MIN:  ea_m_r <= inc_sixty(ea_m_r);
                    default:  e_h_r  <= e_h_r;
                endcase
            end else if (bus.tick_1hz) begin
                if (timeout_hit_s) tmo_r <= 8'd0;
                else               tmo_r <= tmo_r + 8'd1;
            end else begin
                tmo_r <= tmo_r;
            end
        end
    end

    assign bus.clock_pause = pause_r;
    assign bus.load        = load_r;
    assign bus.load_hour   = load_hour_r;
    assign bus.load_min    = load_min_r;
    assign bus.load_sec    = load_sec_r;
    assign bus.alarm_hour  = alarm_hour_r;
    assign bus.alarm_min   = alarm_min_r;
    assign bus.edit_field  = field_r;

endmodule

// File: tb/tb_time_set_sequencer.sv
// Self-checking bench for time_set_sequencer: directed scenarios plus random
// button traffic, all compared against a behavioural front-panel model.
module tb_time_set_sequencer;

    localparam int TIMEOUT = 10;
    localparam int AH_DEF  = 7;
    localparam int AM_DEF  = 0;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_MODE = 5'b10000;
    localparam logic [4:0] B_INC  = 5'b01000;
    localparam logic [4:0] B_CONF = 5'b00100;
    localparam logic [4:0] B_CANC = 5'b00010;
    localparam logic [4:0] B_TICK = 5'b00001;

    logic clk_50m = 1'b0;
    logic cr      = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    time_set_sequencer_if bus_if ();

    time_set_sequencer #(
        .TIMEOUT_S(TIMEOUT), .ALARM_HOUR_DEFAULT(AH_DEF), .ALARM_MIN_DEFAULT(AM_DEF)
    ) dut (
        .clk_50m(clk_50m),
        .cr     (cr),
        .bus    (bus_if)
    );

    always #5 clk_50m = ~clk_50m;

    // Model: field index (0 = not editing), edit copies, alarm, idle-second count.
    int m_field, m_eh, m_em, m_es, m_eah, m_eam, m_ah, m_am, m_tmo;
    int m_load, m_lh, m_lm, m_ls;

    function automatic void model_reset();
        m_field = 0; m_eh = 0; m_em = 0; m_es = 0; m_eah = 0; m_eam = 0;
        m_ah = AH_DEF; m_am = AM_DEF; m_tmo = 0;
        m_load = 0; m_lh = 0; m_lm = 0; m_ls = 0;
    endfunction

    function automatic void model_step(input logic [4:0] b, input int ch, input int cm, input int cs);
        m_load = 0;
        if (m_field == 0) begin
            if (b[4]) begin
                m_field = 1; m_eh = ch; m_em = cm; m_es = cs;
            end
            m_tmo = 0;
        end else if (b[1]) begin
            m_field = 0; m_tmo = 0;
        end else if (b[2]) begin
            if (m_field <= 3) begin
                m_load = 1; m_lh = m_eh; m_lm = m_em; m_ls = m_es;
            end else begin
                m_ah = m_eah; m_am = m_eam;
            end
            m_field = 0; m_tmo = 0;
        end else if (b[4]) begin
            m_field = (m_field + 1) % 6;
            if (m_field == 4) begin
                m_eah = m_ah; m_eam = m_am;
            end
            m_tmo = 0;
        end else if (b[3]) begin
            case (m_field)
                1: m_eh  = (m_eh  > 23) ? 0 : (m_eh  + 1) % 24;
                2: m_em  = (m_em  > 59) ? 0 : (m_em  + 1) % 60;
                3: m_es  = (m_es  > 59) ? 0 : (m_es  + 1) % 60;
                4: m_eah = (m_eah > 23) ? 0 : (m_eah + 1) % 24;
                default: m_eam = (m_eam > 59) ? 0 : (m_eam + 1) % 60;
            endcase
            m_tmo = 0;
        end else if (b[0]) begin
            m_tmo = m_tmo + 1;
            if (m_tmo >= TIMEOUT) begin
                m_field = 0; m_tmo = 0;
            end
        end
    endfunction

    function automatic logic [32:0] exp_vec();
        logic pause;
        pause = (m_field >= 1) && (m_field <= 3);
        return {m_load != 0, pause, 3'(m_field), 5'(m_lh), 6'(m_lm), 6'(m_ls), 5'(m_ah), 6'(m_am)};
    endfunction

    function automatic logic [32:0] dut_vec();
        return {bus_if.load, bus_if.clock_pause, bus_if.edit_field, bus_if.load_hour,
                bus_if.load_min, bus_if.load_sec, bus_if.alarm_hour, bus_if.alarm_min};
    endfunction

    task automatic step(input logic [4:0] b);
        bus_if.btn_mode    = b[4];
        bus_if.btn_inc     = b[3];
        bus_if.btn_confirm = b[2];
        bus_if.btn_cancel  = b[1];
        bus_if.tick_1hz    = b[0];
        model_step(b, int'(bus_if.cur_hour), int'(bus_if.cur_min), int'(bus_if.cur_sec));
        @(posedge clk_50m);
        #1;
        bus_if.btn_mode = 1'b0; bus_if.btn_inc = 1'b0; bus_if.btn_confirm = 1'b0;
        bus_if.btn_cancel = 1'b0; bus_if.tick_1hz = 1'b0;
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        bus_if.cur_hour = 5'(h);
        bus_if.cur_min  = 6'(m);
        bus_if.cur_sec  = 6'(s);
    endtask

    task automatic test_reset();
        #2 cr = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_initial: dut %h expected %h", dut_vec(), exp_vec());
        end
        cr = 1'b0;
        set_cur(1, 2, 3);
        step(B_MODE);
        checks++;
        if (bus_if.edit_field !== 3'd1 || bus_if.clock_pause !== 1'b1) begin
            errors++; $display("FAIL reset_enter: field %0d pause %b expected 1 1", bus_if.edit_field, bus_if.clock_pause);
        end
        // Mid-cycle reset must take effect without waiting for a clock edge.
        #2 cr = 1'b1;
        #1;
        model_reset();
        checks++;
        if (bus_if.edit_field !== 3'd0 || bus_if.clock_pause !== 1'b0 || bus_if.load !== 1'b0 ||
            bus_if.alarm_hour !== 5'd7 || bus_if.alarm_min !== 6'd0) begin
            errors++; $display("FAIL reset_async: dut %h expected %h", dut_vec(), exp_vec());
        end
        cr = 1'b0;
        step(B_NONE);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_idle: dut %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_clock_set();
        logic [4:0] seq   [8] = '{B_MODE, B_INC, B_MODE, B_INC, B_MODE, B_INC, B_INC, B_CONF};
        int         field [8] = '{1, 1, 2, 2, 3, 3, 3, 0};
        set_cur(23, 59, 58);
        for (int k = 0; k < 8; k++) begin
            step(seq[k]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL clock_set step %0d: dut %h expected %h", k, dut_vec(), exp_vec());
            end
            checks++;
            if (bus_if.edit_field !== 3'(field[k]) || bus_if.clock_pause !== (k < 7)) begin
                errors++; $display("FAIL clock_set field %0d: field %0d pause %b expected %0d %b",
                                   k, bus_if.edit_field, bus_if.clock_pause, field[k], k < 7);
            end
        end
        checks++;
        if ({bus_if.load, bus_if.load_hour, bus_if.load_min, bus_if.load_sec} !== {1'b1, 5'd0, 6'd0, 6'd0}) begin
            errors++; $display("FAIL clock_set_load: load %b %0d:%0d:%0d expected 1 0:0:0",
                               bus_if.load, bus_if.load_hour, bus_if.load_min, bus_if.load_sec);
        end
        step(B_NONE);
        checks++;
        if (bus_if.load !== 1'b0 || bus_if.load_hour !== 5'd0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL clock_set_hold: dut %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_alarm_set();
        logic [4:0] seq   [14] = '{B_MODE, B_MODE, B_MODE, B_MODE, B_INC, B_INC, B_INC,
                                   B_MODE, B_INC, B_INC, B_INC, B_INC, B_INC, B_CONF};
        int         field [14] = '{1, 2, 3, 4, 4, 4, 4, 5, 5, 5, 5, 5, 5, 0};
        logic       bad_side = 1'b0;
        set_cur(4, 5, 6);
        for (int k = 0; k < 14; k++) begin
            step(seq[k]);
            if (bus_if.load === 1'b1) bad_side = 1'b1;
            if (field[k] >= 4 && bus_if.clock_pause !== 1'b0) bad_side = 1'b1;
            checks++;
            if (dut_vec() !== exp_vec() || bus_if.edit_field !== 3'(field[k])) begin
                errors++; $display("FAIL alarm_set step %0d: dut %h expected %h field %0d", k, dut_vec(), exp_vec(), field[k]);
            end
        end
        checks++;
        if (bus_if.alarm_hour !== 5'd10 || bus_if.alarm_min !== 6'd5) begin
            errors++; $display("FAIL alarm_set_value: %0d:%0d expected 10:5", bus_if.alarm_hour, bus_if.alarm_min);
        end
        checks++;
        if (bad_side !== 1'b0) begin
            errors++; $display("FAIL alarm_set_side: load or pause seen %b expected 0", bad_side);
        end
    endtask

    task automatic test_priority();
        set_cur(12, 34, 56);
        step(B_MODE);
        step(B_MODE);
        step(B_CONF | B_INC | B_MODE);
        checks++;
        if (bus_if.load !== 1'b1 || bus_if.load_min !== 6'd34 || bus_if.edit_field !== 3'd0 ||
            dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL priority_confirm: dut %h expected %h", dut_vec(), exp_vec());
        end
        step(B_MODE);
        step(B_CANC | B_CONF);
        checks++;
        if (bus_if.load !== 1'b0 || bus_if.edit_field !== 3'd0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL priority_cancel: dut %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_timeout();
        set_cur(8, 9, 10);
        step(B_MODE);
        for (int k = 0; k < 9; k++) step(B_TICK);
        step(B_INC | B_TICK);
        for (int k = 0; k < 9; k++) step(B_TICK);
        checks++;
        if (bus_if.edit_field !== 3'd1 || bus_if.clock_pause !== 1'b1 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL timeout_hold: dut %h expected %h", dut_vec(), exp_vec());
        end
        step(B_TICK);
        checks++;
        if (bus_if.edit_field !== 3'd0 || bus_if.clock_pause !== 1'b0 || bus_if.load !== 1'b0 ||
            dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL timeout_expire: dut %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_out_of_range_abort();
        set_cur(27, 5, 6);
        step(B_MODE);
        step(B_INC);
        step(B_CONF);
        checks++;
        if (bus_if.load !== 1'b1 || bus_if.load_hour !== 5'd0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL oor_hour: dut %h expected %h", dut_vec(), exp_vec());
        end
        step(B_MODE);
        step(B_MODE);
        step(B_MODE);
        checks++;
        if (bus_if.edit_field !== 3'd3 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL abort_pre: dut %h expected %h", dut_vec(), exp_vec());
        end
        #2 cr = 1'b1;
        #1;
        model_reset();
        checks++;
        if (bus_if.edit_field !== 3'd0 || bus_if.clock_pause !== 1'b0 || bus_if.load !== 1'b0 ||
            bus_if.alarm_hour !== 5'd7 || bus_if.alarm_min !== 6'd0) begin
            errors++; $display("FAIL abort_reset: dut %h expected %h", dut_vec(), exp_vec());
        end
        cr = 1'b0;
        step(B_CONF);
        checks++;
        if (bus_if.load !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL abort_after: dut %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [4:0] b;
        for (int k = 0; k < 1200; k++) begin
            set_cur($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            b = B_NONE;
            if (($urandom % 3) == 0) b = b | B_TICK;
            if (((k / 40) % 2) == 1) begin
                if (($urandom % 30) == 0) b = b | B_MODE;
            end else begin
                if (($urandom % 6)  == 0) b = b | B_MODE;
                if (($urandom % 4)  == 0) b = b | B_INC;
                if (($urandom % 14) == 0) b = b | B_CONF;
                if (($urandom % 25) == 0) b = b | B_CANC;
            end
            step(b);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random step %0d btn %b: dut %h expected %h", k, b, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus_if.btn_mode = 1'b0; bus_if.btn_inc = 1'b0; bus_if.btn_confirm = 1'b0;
        bus_if.btn_cancel = 1'b0; bus_if.tick_1hz = 1'b0;
        set_cur(0, 0, 0);
        model_reset();
        test_reset();
        test_clock_set();
        test_alarm_set();
        test_priority();
        test_timeout();
        test_out_of_range_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
